gl_ras_ctrl: RTL and testbench
==============================

GL_RAS_CTRL -- requirements
Module: gl_ras_ctrl

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous assert, active-high.
REQ-003 vtx_empty  in  1  vertex FIFO empty flag.
REQ-004 vtx_data  in  96  vertex FIFO head word {x[95:64], y[63:32], z[31:0]}, IEEE-754 single; valid while vtx_empty low.
REQ-005 vtx_rd  out  1  vertex FIFO pop strobe; one word consumed per cycle high.
REQ-006 ras_in1, ras_in2, ras_in3  out  96 each  registered triangle vertices to rasterizer.
REQ-007 ras_go  out  1  rasterizer advance enable (drives rasterizer fifo_ready).
REQ-008 ras_x, ras_y  in  32 each  rasterizer current pixel coordinates.
REQ-009 ras_true  in  1  current pixel inside triangle.
REQ-010 ras_done  in  1  one-cycle pulse: rasterizer finished triangle (raster_ready).
REQ-011 frag_valid  out  1  fragment output valid.
REQ-012 frag_x, frag_y  out  32 each  fragment coordinates.
REQ-013 frag_ready  in  1  downstream accepts fragment when high with frag_valid.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 tri_count  out  16  triangles completed, wraps 0xFFFF->0x0000.

Function
REQ-016 FSM states: IDLE, LOAD0, LOAD1, LOAD2, START, RUN, DRAIN.
REQ-017 IDLE->LOAD0 when vtx_empty low.
REQ-018 LOADn: if vtx_empty low, assert vtx_rd and latch vtx_data into ras_in(n+1), advance; if vtx_empty high, hold state with vtx_rd low.
REQ-019 LOAD2->START after third latch; START lasts exactly one cycle with ras_go low, giving rasterizer stable vertices.
REQ-020 START->RUN; in RUN, ras_go high when fragment buffer count==0, or count==1 and a pop occurs this cycle; else low.
REQ-021 Fragment buffer: 2-entry FIFO of {x,y}; pushed each RUN cycle where ras_true high; popped when frag_valid && frag_ready; push and pop in same cycle leave count unchanged.
REQ-022 frag_valid = buffer count != 0; frag_x/frag_y = buffer head.
REQ-023 Push to full buffer without simultaneous pop is dropped; RTL carries a simulation-only assertion on it.
REQ-024 RUN->DRAIN on ras_done; a ras_true in the ras_done cycle is still pushed.
REQ-025 DRAIN: ras_go low; ->IDLE when buffer empty (same cycle as last pop allowed), tri_count increments by 1 on that transition.
REQ-026 ras_done outside RUN ignored.
REQ-027 ras_in1..3 hold values until next LOAD overwrites them.
REQ-028 vtx_rd never high outside LOAD0..LOAD2.

Reset
REQ-029 On rst: state IDLE, vtx_rd 0, ras_go 0, ras_in1..3 0, buffer count 0, frag_valid 0, frag_x/frag_y 0, busy 0, tri_count 0.
REQ-030 rst mid-triangle discards latched vertices and buffered fragments; no vertex FIFO pop occurs while rst high.

Configuration
REQ-031 Macro GL_RAS_CULL_EN: when defined, in LOAD2->START decision any two vertices with identical x and y bit patterns mark triangle degenerate; FSM goes to IDLE instead of START, ras_go stays low, tri_count unchanged, and 16-bit output cull_count increments (wrap).
REQ-032 Without GL_RAS_CULL_EN: no cull_count port; every triangle goes to START.

Verification
REQ-033 Load (1,10,0),(1,1,0),(10,1,0) (0x3F800000_41200000_00000000 etc.), frag_ready=1, rasterizer model emits 5 true pixels then ras_done -> 5 fragments in order, tri_count=1, busy low after DRAIN.
REQ-034 vtx_empty high for 3 cycles between 2nd and 3rd vertex -> FSM holds LOAD2, exactly 3 vtx_rd pulses, ras_in3 = third word.
REQ-035 frag_ready low for 10 cycles during RUN with ras_true every cycle -> ras_go low after buffer holds 1+1 in-flight, no dropped fragment, count never exceeds 2.
REQ-036 ras_done with ras_true same cycle, frag_ready low 4 cycles -> fragment kept, DRAIN 4+ cycles, tri_count increments on exit only.
REQ-037 rst asserted in RUN with 2 buffered fragments -> all outputs at reset values asynchronously, restart loads next three words cleanly.
REQ-038 GL_RAS_CULL_EN defined, vertices (1,1),(1,1),(10,1) -> no START, cull_count=1, tri_count=0; undefined -> triangle rasterized, tri_count=1.

Source files
------------

// File: rtl/gl_ras_if.sv
// gl_ras_if: vertex FIFO, rasterizer and fragment signals of gl_ras_ctrl.
interface gl_ras_if;
  logic        vtx_empty;
  logic [95:0] vtx_data;
  logic        vtx_rd;
  logic [95:0] ras_in1, ras_in2, ras_in3;
  logic        ras_go;
  logic [31:0] ras_x, ras_y;
  logic        ras_true, ras_done;
  logic        frag_valid;
  logic [31:0] frag_x, frag_y;
  logic        frag_ready;
  logic        busy;
  logic [15:0] tri_count;
  modport master (
    input  vtx_empty, vtx_data, ras_x, ras_y, ras_true, ras_done, frag_ready,
    output vtx_rd, ras_in1, ras_in2, ras_in3, ras_go, frag_valid, frag_x, frag_y, busy, tri_count
  );
  modport slave (
    output vtx_empty, vtx_data, ras_x, ras_y, ras_true, ras_done, frag_ready,
    input  vtx_rd, ras_in1, ras_in2, ras_in3, ras_go, frag_valid, frag_x, frag_y, busy, tri_count
  );
endinterface

// File: rtl/gl_ras_ctrl.sv
// gl_ras_ctrl: loads triangle vertices, paces the rasterizer and buffers fragments.
// GL_RAS_CULL_EN: drop triangles with coincident x/y vertices, counted on cull_count.
module gl_ras_ctrl (
  input  logic        clk,
  input  logic        rst,
`ifdef GL_RAS_CULL_EN
  output logic [15:0] cull_count,
`endif
  gl_ras_if.master    bus
);
  typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, LOAD2, START, RUN, DRAIN} state_t;
  state_t      state, state_nx;
  logic [63:0] fbuf [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  cnt;
  logic        push, pop, wr, last, degen;
  assign pop  = bus.frag_valid && bus.frag_ready;
  assign push = (state == RUN) && bus.ras_true;
  assign wr   = push && (cnt != 2'd2 || pop);
  // buffer has room for the pixel the rasterizer will present next cycle
  assign last = (cnt == 2'd0) || (cnt == 2'd1 && pop);
`ifdef GL_RAS_CULL_EN
  assign degen = (bus.vtx_data[95:32] == bus.ras_in1[95:32]) ||
                 (bus.vtx_data[95:32] == bus.ras_in2[95:32]) ||
                 (bus.ras_in1[95:32]  == bus.ras_in2[95:32]);
`else
  assign degen = 1'b0;
`endif
  assign bus.vtx_rd     = !bus.vtx_empty && (state inside {LOAD0, LOAD1, LOAD2});
  assign bus.ras_go     = (state == RUN) && last;
  assign bus.frag_valid = cnt != 2'd0;
  assign bus.frag_x     = fbuf[rd_ptr][63:32];
  assign bus.frag_y     = fbuf[rd_ptr][31:0];
  assign bus.busy       = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.vtx_empty ? IDLE : LOAD0;
      LOAD0:   state_nx = bus.vtx_empty ? LOAD0 : LOAD1;
      LOAD1:   state_nx = bus.vtx_empty ? LOAD1 : LOAD2;
      LOAD2:   state_nx = bus.vtx_empty ? LOAD2 : (degen ? IDLE : START);
      START:   state_nx = RUN;
      RUN:     state_nx = bus.ras_done ? DRAIN : RUN;
      DRAIN:   state_nx = last ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.ras_in1   <= '0;
      bus.ras_in2   <= '0;
      bus.ras_in3   <= '0;
      fbuf[0]       <= '0;
      fbuf[1]       <= '0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      cnt           <= 2'd0;
      bus.tri_count <= '0;
    end else begin
      state <= state_nx;
      if (bus.vtx_rd && state == LOAD0) bus.ras_in1 <= bus.vtx_data;
      if (bus.vtx_rd && state == LOAD1) bus.ras_in2 <= bus.vtx_data;
      if (bus.vtx_rd && state == LOAD2) bus.ras_in3 <= bus.vtx_data;
      if (wr) begin
        fbuf[wr_ptr] <= {bus.ras_x, bus.ras_y};
        wr_ptr       <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      cnt <= cnt + {1'b0, wr} - {1'b0, pop};
      if (state == DRAIN && last) bus.tri_count <= bus.tri_count + 16'd1;
    end
  end
`ifdef GL_RAS_CULL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cull_count <= '0;
    else if (bus.vtx_rd && state == LOAD2 && degen) cull_count <= cull_count + 16'd1;
  end
`endif
`ifndef SYNTHESIS
  frag_drop: assert property (@(posedge clk) disable iff (rst) !(push && cnt == 2'd2 && !pop));
`endif
endmodule

// File: tb/tb_gl_ras_ctrl.sv
// tb_gl_ras_ctrl: directed bench with vertex FIFO and rasterizer models and a fragment scoreboard.
module tb_gl_ras_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  gl_ras_if bus();
`ifdef GL_RAS_CULL_EN
  logic [15:0] cull_count;
  gl_ras_ctrl dut (.clk(clk), .rst(rst), .cull_count(cull_count), .bus(bus));
`else
  gl_ras_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  int checks = 0, errors = 0;
  logic [95:0] vq[$];
  logic [63:0] sb[$];
  int pix_left = 0, pix_id = 1, pops = 0, rd_pulses = 0, max_q = 0;
  bit done_last = 0, done_next = 0, done_seen = 0, go_prev = 0, ready = 1;
  localparam logic [95:0] V1 = {32'h3F800000, 32'h41200000, 32'h0};
  localparam logic [95:0] V2 = {32'h3F800000, 32'h3F800000, 32'h0};
  localparam logic [95:0] V3 = {32'h41200000, 32'h3F800000, 32'h0};
  task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic arm(int n, bit dl);
    pix_left = n; done_last = dl; done_next = 0; done_seen = 0;
  endtask
  // drive inputs just after negedge, sample 1 ns later, let the posedge consume them
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    bus.frag_ready = ready;
    bus.vtx_empty  = vq.size() == 0;
    bus.vtx_data   = vq.size() != 0 ? vq[0] : '0;
    bus.ras_true   = 1'b0;
    bus.ras_done   = 1'b0;
    if (done_next) begin
      bus.ras_done = 1'b1; done_next = 0; done_seen = 1;
    end else if (go_prev && pix_left > 0) begin
      bus.ras_true = 1'b1;
      bus.ras_x = pix_id;
      bus.ras_y = pix_id * 3 + 7;
      pix_id++; pix_left--;
      sb.push_back({bus.ras_x, bus.ras_y});
      if (pix_left == 0) begin
        if (done_last) begin bus.ras_done = 1'b1; done_seen = 1; end
        else done_next = 1;
      end
    end
    #1;
    if (bus.frag_valid && bus.frag_ready) begin
      e = 'x;
      if (sb.size() != 0) e = sb.pop_front();
      chk("frag", {32'h0, bus.frag_x, bus.frag_y}, {32'h0, e});
      pops++;
    end
    if (sb.size() > max_q) max_q = sb.size();
    go_prev = bus.ras_go;
    if (bus.vtx_rd) begin
      if (vq.size() != 0) void'(vq.pop_front());
      rd_pulses++;
    end
  endtask
  task automatic run_tri(int lim);
    int n = 0;
    do begin tick(); n++; end while (!bus.busy && n < lim);
    do begin tick(); n++; end while (bus.busy && n < lim);
    chk("timeout", n < lim, 1);
  endtask
  initial begin
    bus.frag_ready = 1'b1; bus.vtx_empty = 1'b1; bus.vtx_data = '0;
    bus.ras_x = '0; bus.ras_y = '0; bus.ras_true = 1'b0; bus.ras_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_vtx_rd", bus.vtx_rd, 0);
    chk("rst_ras_go", bus.ras_go, 0);
    chk("rst_frag_valid", bus.frag_valid, 0);
    chk("rst_frag_xy", {bus.frag_x, bus.frag_y}, 0);
    chk("rst_ras_in", bus.ras_in1 | bus.ras_in2 | bus.ras_in3, 0);
    chk("rst_tri_count", bus.tri_count, 0);
    rst = 1'b0;
    // basic triangle, five pixels, downstream always ready
    vq = {V1, V2, V3}; arm(5, 0); pops = 0;
    for (int i = 0; i < 20 && rd_pulses < 3; i++) tick();
    chk("a_loads", rd_pulses, 3);
    tick();
    chk("a_start_go", bus.ras_go, 0);
    chk("a_start_busy", bus.busy, 1);
    tick();
    chk("a_run_go", bus.ras_go, 1);
    run_tri(100);
    chk("a_pops", pops, 5);
    chk("a_tri_count", bus.tri_count, 1);
    chk("a_busy", bus.busy, 0);
    chk("a_ras_in1", bus.ras_in1, V1);
    chk("a_ras_in2", bus.ras_in2, V2);
    chk("a_ras_in3", bus.ras_in3, V3);
    chk("a_sb_empty", sb.size(), 0);
    // vertex FIFO runs dry before the third vertex
    vq = {96'h1, 96'h2}; arm(2, 0);
    for (int i = 0; i < 20 && rd_pulses < 5; i++) tick();
    repeat (3) tick();
    chk("b_hold_rd", rd_pulses, 5);
    chk("b_hold_busy", bus.busy, 1);
    vq.push_back(96'h3);
    run_tri(100);
    chk("b_rd_pulses", rd_pulses, 6);
    chk("b_ras_in1", bus.ras_in1, 96'h1);
    chk("b_ras_in3", bus.ras_in3, 96'h3);
    chk("b_tri_count", bus.tri_count, 2);
    // downstream stall for 10 cycles mid-triangle
    vq = {96'h11, 96'h12, 96'h13}; arm(12, 0); pops = 0; max_q = 0;
    for (int i = 0; i < 40 && !bus.frag_valid; i++) tick();
    ready = 0;
    repeat (10) tick();
    chk("c_stall_go", bus.ras_go, 0);
    chk("c_stall_fill", sb.size(), 2);
    chk("c_stall_valid", bus.frag_valid, 1);
    ready = 1;
    run_tri(200);
    chk("c_max_fill", max_q, 2);
    chk("c_pops", pops, 12);
    chk("c_tri_count", bus.tri_count, 3);
    // last pixel arrives with ras_done while downstream stalls
    vq = {96'h21, 96'h22, 96'h23}; arm(1, 1); ready = 0;
    for (int i = 0; i < 40 && !done_seen; i++) tick();
    repeat (4) tick();
    chk("d_drain_busy", bus.busy, 1);
    chk("d_drain_valid", bus.frag_valid, 1);
    chk("d_drain_go", bus.ras_go, 0);
    chk("d_drain_tri", bus.tri_count, 3);
    ready = 1;
    run_tri(100);
    chk("d_tri_count", bus.tri_count, 4);
    chk("d_sb_empty", sb.size(), 0);
    // asynchronous reset with two buffered fragments
    vq = {96'h31, 96'h32, 96'h33, 96'h41, 96'h42, 96'h43}; arm(20, 0); ready = 0;
    for (int i = 0; i < 40 && sb.size() < 2; i++) tick();
    chk("e_fill", sb.size(), 2);
    #2 rst = 1'b1;
    #1;
    chk("e_rst_busy", bus.busy, 0);
    chk("e_rst_valid", bus.frag_valid, 0);
    chk("e_rst_go", bus.ras_go, 0);
    chk("e_rst_ras_in1", bus.ras_in1, 0);
    chk("e_rst_tri", bus.tri_count, 0);
    sb.delete(); arm(0, 0); go_prev = 0; rd_pulses = 0;
    repeat (2) tick();
    chk("e_rst_no_pop", rd_pulses, 0);
    rst = 1'b0;
    ready = 1; arm(3, 0);
    run_tri(100);
    chk("e_rd_pulses", rd_pulses, 3);
    chk("e_ras_in1", bus.ras_in1, 96'h41);
    chk("e_ras_in2", bus.ras_in2, 96'h42);
    chk("e_ras_in3", bus.ras_in3, 96'h43);
    chk("e_tri_count", bus.tri_count, 1);
    // degenerate triangle: two vertices share x and y
    vq = {V2, V2, V3}; arm(2, 0);
    run_tri(100);
`ifdef GL_RAS_CULL_EN
    chk("f_cull_count", cull_count, 1);
    chk("f_tri_count", bus.tri_count, 1);
    chk("f_no_raster", pix_left, 2);
`else
    chk("f_tri_count", bus.tri_count, 2);
    chk("f_rastered", pix_left, 0);
`endif
    chk("f_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
